// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry and
// the loader FSM state encoding.
package imem_loader_pkg;

    localparam int RV_BIT_NUM         = 32;
    localparam int IMEMM_ADDR_BIT_NUM = 8;
    localparam int IMEMM_DEPTH        = 256;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_RECV  = 2'd1,
        LDR_WRITE = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian DATA_W-bit word from a byte stream; flags the
// cycle in which the final byte of a word is accepted.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = RV_BIT_NUM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            for (int k = 0; k < BYTES; k++) begin
                if (r_idx == IDX_W'(k)) r_word[8*k +: 8] <= i_byte;
            end
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = i_accept && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Host-to-imem loader: packs host bytes into words, writes them sequentially,
// and otherwise forwards the core fetch address to imem.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = RV_BIT_NUM,
    parameter int ADDR_W = IMEMM_ADDR_BIT_NUM,
    parameter int DEPTH  = IMEMM_DEPTH
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_stall,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [DATA_W-1:0] checksum
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    ldr_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_words_left;
    logic [DATA_W-1:0] r_checksum;
    logic              r_done, r_err;

    logic              w_start_ok, w_len_zero, w_len_over, w_last_word;
    logic              w_accept, w_word_valid;
    logic [DATA_W-1:0] w_word;

    assign w_start_ok  = load_start && (r_state == LDR_IDLE || r_state == LDR_DONE);
    assign w_len_zero  = (load_len == '0);
    assign w_len_over  = (load_len > DEPTH_L);
    assign w_last_word = (r_words_left == LEN_W'(1));
    assign w_accept    = s_valid && (r_state == LDR_RECV);

    imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (clka),
        .rst_n        (rsta),
        .i_clear      (w_start_ok),
        .i_accept     (w_accept),
        .i_byte       (s_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) r_state <= LDR_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_next = r_state;
        wea          = 1'b0;
        addra        = core_addr;
        dina         = '0;
        case (r_state)
            LDR_IDLE, LDR_DONE: begin
                if (w_start_ok)
                    w_state_next = (w_len_zero || w_len_over) ? LDR_DONE : LDR_RECV;
            end
            LDR_RECV: begin
                addra = r_addr;
                if (w_word_valid) w_state_next = LDR_WRITE;
            end
            LDR_WRITE: begin
                wea          = 1'b1;
                addra        = r_addr;
                dina         = w_word;
                w_state_next = w_last_word ? LDR_DONE : LDR_RECV;
            end
            default: w_state_next = LDR_IDLE;
        endcase
    end

    // imem itself sits outside this reset domain; only loader bookkeeping clears.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_checksum   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_start_ok) begin
            r_addr       <= '0;
            r_checksum   <= '0;
            r_words_left <= (w_len_zero || w_len_over) ? '0 : load_len;
            r_done       <= w_len_zero || w_len_over;
            r_err        <= w_len_over;
        end else if (r_state == LDR_WRITE) begin
            r_checksum   <= r_checksum + w_word;
            r_addr       <= r_addr + 1'b1;
            r_words_left <= r_words_left - 1'b1;
            if (w_last_word) r_done <= 1'b1;
        end
    end

    assign s_ready    = (r_state == LDR_RECV);
    assign load_busy  = (r_state == LDR_RECV) || (r_state == LDR_WRITE);
    assign core_stall = load_busy;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader paired with a behavioural imem; writes
// are predicted into a scoreboard queue and matched when wea is observed.
module tb_imem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clka = 1'b0;
    logic              rsta;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] core_addr;
    logic              core_stall;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [DATA_W-1:0] checksum;

    always #5 clka = ~clka;

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .load_start (load_start),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .core_addr  (core_addr),
        .core_stall (core_stall),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .checksum   (checksum)
    );

    // Behavioural imem: synchronous write, one-cycle read; mem_init preloads a pattern.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] douta;
    logic              mem_init = 1'b1;

    always @(posedge clka) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA000_0000 + DATA_W'(i);
        end else if (wea) begin
            mem[addra] <= dina;
        end
        douta <= mem[addra];
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [ADDR_W+DATA_W-1:0] sb [$];
    int wea_count = 0;

    always @(negedge clka) begin
        if (wea === 1'b1) begin
            wea_count++;
            if (sb.size() == 0) begin
                check("wea_unexpected", 1, 0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = sb.pop_front();
                check("wr_addr", addra, e[ADDR_W+DATA_W-1:DATA_W]);
                check("wr_data", dina, e[DATA_W-1:0]);
            end
        end
    end

    int first_acc;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic start_load(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        tick();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input logic [ADDR_W-1:0] a,
                             input int gap_after);
        sb.push_back({a, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (k == 0) first_acc = cyc;
            if (k == gap_after) begin
                s_valid = 1'b0;
                repeat (3) tick();
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 40) begin
            tick();
            n++;
        end
        check(tag, load_done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base;
        logic [DATA_W-1:0] w, exp_sum;

        rsta = 1'b0; load_start = 1'b0; load_len = '0;
        s_valid = 1'b0; s_data = '0; core_addr = 4'd5;

        // Reset and idle fetch pass-through
        tick(); tick();
        rsta = 1'b1; mem_init = 1'b0;
        tick();
        check("idle_addra", addra, 5);
        check("idle_wea", wea, 0);
        check("idle_s_ready", s_ready, 0);
        check("idle_stall", core_stall, 0);
        check("idle_busy", load_busy, 0);
        check("idle_done", load_done, 0);
        check("idle_err", load_err, 0);
        check("idle_checksum", checksum, 0);
        check("idle_dina", dina, 0);
        check("fetch_douta5", douta, 32'hA000_0005);

        // Two-word back-to-back load with cycle count
        start_load(2);
        check("recv_addra", addra, 0);
        check("recv_stall", core_stall, 1);
        check("recv_s_ready", s_ready, 1);
        send_word(32'h0000_0013, 0, -1);
        t0 = first_acc;
        send_word(32'h0010_0093, 1, -1);
        s_valid = 1'b0;
        wait_done("l2_done");
        check("l2_cycles", cyc - t0 + 1, 10);
        check("l2_checksum", checksum, 32'h0010_00A6);
        check("l2_mem0", mem[0], 32'h0000_0013);
        check("l2_mem1", mem[1], 32'h0010_0093);
        check("l2_busy", load_busy, 0);
        check("l2_addra", addra, 5);
        core_addr = 4'd1;
        tick();
        check("l2_fetch1", douta, 32'h0010_0093);

        // Same load with a stalled host between bytes
        mem_init = 1'b1; tick(); mem_init = 1'b0;
        base = wea_count;
        start_load(2);
        send_word(32'h0000_0013, 0, 1);
        send_word(32'h0010_0093, 1, -1);
        s_valid = 1'b0;
        wait_done("gap_done");
        check("gap_wea_count", wea_count - base, 2);
        check("gap_mem0", mem[0], 32'h0000_0013);
        check("gap_mem1", mem[1], 32'h0010_0093);
        check("gap_checksum", checksum, 32'h0010_00A6);

        // Length boundaries: zero, DEPTH+1, exactly DEPTH
        base = wea_count;
        start_load(0);
        check("len0_done", load_done, 1);
        check("len0_err", load_err, 0);
        check("len0_busy", load_busy, 0);
        check("len0_checksum", checksum, 0);
        start_load(DEPTH + 1);
        check("over_done", load_done, 1);
        check("over_err", load_err, 1);
        check("over_busy", load_busy, 0);
        tick(); tick();
        check("bad_len_wea", wea_count - base, 0);

        start_load(DEPTH);
        check("full_err_clr", load_err, 0);
        check("full_done_clr", load_done, 0);
        check("full_busy", load_busy, 1);
        exp_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom();
            exp_sum += w;
            send_word(w, ADDR_W'(i), -1);
        end
        s_valid = 1'b0;
        wait_done("full_done");
        check("full_err", load_err, 0);
        check("full_checksum", checksum, exp_sum);

        // load_start while busy is ignored
        base = wea_count;
        start_load(2);
        sb.push_back({ADDR_W'(0), 32'hDEAD_BEEF});
        send_byte(8'hEF);
        send_byte(8'hBE);
        s_valid = 1'b0;
        start_load(5);
        check("ign_addra", addra, 0);
        check("ign_busy", load_busy, 1);
        send_byte(8'hAD);
        send_byte(8'hDE);
        send_word(32'h1234_5678, 1, -1);
        s_valid = 1'b0;
        wait_done("ign_done");
        check("ign_wea_count", wea_count - base, 2);
        check("ign_checksum", checksum, 32'hDEAD_BEEF + 32'h1234_5678);
        check("ign_mem0", mem[0], 32'hDEAD_BEEF);
        check("ign_mem1", mem[1], 32'h1234_5678);

        // Reset in the middle of the second word
        core_addr = '0;
        start_load(2);
        send_word(32'hCAFE_F00D, 0, -1);
        send_byte(8'h01);
        send_byte(8'h02);
        s_valid = 1'b0;
        #2 rsta = 1'b0;
        #1;
        check("rst_wea", wea, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_stall", core_stall, 0);
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_checksum", checksum, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        tick();
        check("rst_mem0_kept", mem[0], 32'hCAFE_F00D);
        rsta = 1'b1;
        tick();
        start_load(1);
        send_word(32'h0BAD_C0DE, 0, -1);
        s_valid = 1'b0;
        wait_done("relo_done");
        check("relo_mem0", mem[0], 32'h0BAD_C0DE);
        check("relo_checksum", checksum, 32'h0BAD_C0DE);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Initiator side of the instruction-memory write/read port.
- Accepts a byte stream from the host link, assembles little-endian 32-bit instruction words, and writes them sequentially into imem via wea/addra/dina.
- Outside a load, passes the core's fetch address through to imem and stalls the core while a load is in progress.
- Reports completion, a running word checksum, and a length error.

Parameters:
- DATA_W, `RV_BIT_NUM (32): instruction word width; must be a multiple of 8.
- ADDR_W, `IMEMM_ADDR_BIT_NUM: imem word-address width.
- DEPTH, `IMEMM_DEPTH: imem depth in words.

Ports:
- clka  in  1  clock; all state on its rising edge.
- rsta  in  1  reset; asynchronous, active-low.
- load_start  in  1  single-cycle request to begin a load.
- load_len  in  ADDR_W+1  number of words to load; sampled on an accepted load_start.
- s_valid  in  1  host byte valid.
- s_data  in  8  host byte.
- s_ready  out  1  loader accepts the byte this cycle.
- core_addr  in  ADDR_W  core fetch word address.
- core_stall  out  1  core must hold its fetch; high while loading.
- wea  out  1  imem write enable.
- addra  out  ADDR_W  imem address.
- dina  out  DATA_W  imem write data.
- load_busy  out  1  FSM is in RECV or WRITE.
- load_done  out  1  last load finished; sticky until next accepted load_start.
- load_err  out  1  last load_len exceeded DEPTH; sticky like load_done.
- checksum  out  DATA_W  sum mod 2^DATA_W of words written in current/last load.

Behaviour:
- Reset (rsta low, asynchronous): all outputs 0, FSM=IDLE, counters 0. imem contents untouched. Reset mid-load abandons the load; words already written remain in imem.
- FSM states:
  - IDLE: waiting for load_start.
  - RECV: collecting bytes.
  - WRITE: one-cycle imem write.
  - DONE: load finished; same fetch behaviour as IDLE.
- IDLE/DONE on load_start:
  - Clear checksum, word address and byte index; clear load_done and load_err.
  - load_len==0: next state DONE, load_done=1, no write.
  - load_len>DEPTH: next state DONE, load_done=1, load_err=1, no write.
  - Otherwise: latch words_left=load_len, next state RECV.
- load_start while busy is ignored.
- RECV:
  - s_ready=1. A byte is accepted when s_valid&&s_ready.
  - Byte k (k=0..3) goes to word bits [8k+7:8k]; byte index wraps 3->0.
  - Accepting byte 3 moves to WRITE on the next edge.
- WRITE (exactly one cycle):
  - s_ready=0, wea=1, addra=word address, dina=assembled word.
  - On exit: checksum+=word (wraps), word address+1, words_left-1.
  - words_left reaching 0 goes to DONE with load_done=1; otherwise back to RECV.
  - Peak rate is 1 word per 5 cycles.
- Fetch mux:
  - In IDLE/DONE: wea=0, addra=core_addr, dina=0.
  - imem returns douta one cycle after addra, so fetch latency is 1 cycle.
- core_stall = load_busy. In RECV, addra holds the current word address with wea=0.
- All outputs are combinational from registered state; the only input-to-output path is core_addr->addra.
- The word address never exceeds DEPTH-1 because load_len is range-checked.

Decomposition:
- Shared header macro_para.v holds:
  - `RV_BIT_NUM, `IMEMM_ADDR_BIT_NUM, `IMEMM_DEPTH;
  - state encodings `LDR_IDLE/`LDR_RECV/`LDR_WRITE/`LDR_DONE (2-bit).
- One natural sub-module: byte_packer (byte index, shift-in, word_valid), instantiated by imem_loader.
- Bench pairs imem_loader with the existing imem.

Test Plan:
- Reset then idle, core_addr=5 -> addra=5, wea=0, s_ready=0, core_stall=0; douta shows imem[5] one cycle later.
- load_start, load_len=2, bytes 13 00 00 00 93 00 10 00 sent back-to-back -> imem[0]=0x00000013, imem[1]=0x00100093; checksum=0x001000A6; load_done=1; total 10 cycles from first byte accept to DONE.
- Same load with s_valid low for 3 cycles between bytes 1 and 2 -> identical imem contents; wea pulses exactly twice.
- load_len=0 -> load_done=1 next cycle, no wea; load_len=DEPTH+1 -> load_err=1, load_done=1, no wea.
- load_start pulsed during RECV -> ignored: words_left and address unchanged, load completes normally.
- rsta low after byte 2 of word 1 -> outputs 0, FSM IDLE, imem[0] retained; a new load of 1 word writes imem[0] afresh.
